// File: rtl/fluorescence_pkg.sv
// Shared state encoding and counter defaults for the PMT pulse conditioner.
package fluorescence_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    QUALIFY = ST_QUALIFY,
    DEAD    = ST_DEAD,
    HOLD    = ST_HOLD
  } pmt_state_e;

  localparam int                    CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0]  CNT_MAX   = '1;

endpackage

// File: rtl/pmt_sync.sv
// Multi-flop synchroniser for the asynchronous PMT discriminator output.
// Resets to 1 so a line already high at reset release is not seen as an edge.
module pmt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_50_mhz,
  input  logic reset_n,
  input  logic d,
  output logic s
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= sync_d;
  end

  assign s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pmt_pulse_conditioner.sv
// PMT front end: synchronise, reject short glitches, enforce dead time, tag phase.
// Define PMT_PILEUP_CNT_EN to build the pile-up diagnostic counter.
//
// state   | meaning
// IDLE    | waiting for a rising edge of the synchronised input
// QUALIFY | input high, counting towards the minimum width
// DEAD    | pulse accepted, dead-time counter running
// HOLD    | dead time over but input still high; wait for the fall
module pmt_pulse_conditioner
  import fluorescence_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_W_W     = 8,
  parameter int DEAD_W      = 16,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clock_50_mhz,
  input  logic               reset_n,
  input  logic               pmt_in,
  input  logic               light_source_flag,
  input  logic [MIN_W_W-1:0] min_width,
  input  logic [DEAD_W-1:0]  dead_time,
  input  logic               clear_counts,
  output logic               pulse_valid,
  output logic               pulse_phase,
  output logic [CNT_W-1:0]   glitch_count,
  output logic [CNT_W-1:0]   pile_up_count
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic s;

  pmt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_50_mhz (clock_50_mhz),
    .reset_n      (reset_n),
    .d            (pmt_in),
    .s            (s)
  );

  pmt_state_e         state_q, state_d;
  logic               prev_q, prev_d;
  logic               phase_q, phase_d;
  logic [MIN_W_W-1:0] wmax_q, wmax_d;
  logic [MIN_W_W-1:0] wcnt_q, wcnt_d;
  logic [DEAD_W-1:0]  dcnt_q, dcnt_d;
  logic               pulse_valid_q, pulse_valid_d;
  logic               pulse_phase_q, pulse_phase_d;
  logic [CNT_W-1:0]   glitch_q, glitch_d;
  logic [MIN_W_W-1:0] wmax_at_e;
  logic               rise, accept, glitch;

  assign rise      = s & ~prev_q;
  assign wmax_at_e = (min_width == '0) ? MIN_W_W'(1) : min_width;

  always_comb begin
    state_d       = state_q;
    prev_d        = s;
    phase_d       = phase_q;
    wmax_d        = wmax_q;
    wcnt_d        = wcnt_q;
    dcnt_d        = dcnt_q;
    accept        = 1'b0;
    glitch        = 1'b0;
    pulse_phase_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          phase_d = light_source_flag;
          wmax_d  = wmax_at_e;
          wcnt_d  = MIN_W_W'(1);
          // A one-cycle minimum width is satisfied by the edge cycle itself.
          if (wmax_at_e == MIN_W_W'(1)) begin
            accept        = 1'b1;
            pulse_phase_d = light_source_flag;
          end else begin
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (!s) begin
          glitch  = 1'b1;
          state_d = IDLE;
        end else if ((wcnt_q + MIN_W_W'(1)) == wmax_q) begin
          accept        = 1'b1;
          pulse_phase_d = phase_q;
          wcnt_d        = wmax_q;
        end else begin
          wcnt_d = wcnt_q + MIN_W_W'(1);
        end
      end
      DEAD: begin
        if (dcnt_q == '0) state_d = s ? HOLD : IDLE;
        else              dcnt_d  = dcnt_q - DEAD_W'(1);
      end
      HOLD: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      dcnt_d  = dead_time;
      state_d = DEAD;
    end
    pulse_valid_d = accept;
  end

  always_comb begin
    glitch_d = glitch_q;
    if (clear_counts)                        glitch_d = '0;
    else if (glitch && (glitch_q != CNT_SAT)) glitch_d = glitch_q + CNT_W'(1);
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      prev_q        <= 1'b1;
      phase_q       <= 1'b0;
      wmax_q        <= '0;
      wcnt_q        <= '0;
      dcnt_q        <= '0;
      pulse_valid_q <= 1'b0;
      pulse_phase_q <= 1'b0;
      glitch_q      <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      phase_q       <= phase_d;
      wmax_q        <= wmax_d;
      wcnt_q        <= wcnt_d;
      dcnt_q        <= dcnt_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_phase_q <= pulse_phase_d;
      glitch_q      <= glitch_d;
    end
  end

  assign pulse_valid  = pulse_valid_q;
  assign pulse_phase  = pulse_phase_q;
  assign glitch_count = glitch_q;

`ifdef PMT_PILEUP_CNT_EN
  logic             pile_up;
  logic [CNT_W-1:0] pile_q, pile_d;

  assign pile_up = rise && ((state_q == DEAD) || (state_q == HOLD));

  always_comb begin
    pile_d = pile_q;
    if (clear_counts)                        pile_d = '0;
    else if (pile_up && (pile_q != CNT_SAT)) pile_d = pile_q + CNT_W'(1);
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) pile_q <= '0;
    else          pile_q <= pile_d;
  end

  assign pile_up_count = pile_q;
`else
  assign pile_up_count = '0;
`endif

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Self-checking bench for pmt_pulse_conditioner against an event-level reference model.
module tb_pmt_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int MW_W = 8;
  localparam int DT_W = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MAXN = 4096;

  logic            clock_50_mhz = 1'b0;
  logic            reset_n = 1'b0;
  logic            pmt_in = 1'b0;
  logic            light_source_flag = 1'b0;
  logic [MW_W-1:0] min_width = '0;
  logic [DT_W-1:0] dead_time = '0;
  logic            clear_counts = 1'b0;
  logic            pulse_valid, pulse_phase;
  logic [CW-1:0]   glitch_count, pile_up_count;

  int vectors = 0;
  int miscompares = 0;

  always #10 clock_50_mhz = ~clock_50_mhz;

  pmt_pulse_conditioner #(
    .SYNC_STAGES(SYNC), .MIN_W_W(MW_W), .DEAD_W(DT_W), .CNT_W(CW)
  ) dut (
    .clock_50_mhz      (clock_50_mhz),
    .reset_n           (reset_n),
    .pmt_in            (pmt_in),
    .light_source_flag (light_source_flag),
    .min_width         (min_width),
    .dead_time         (dead_time),
    .clear_counts      (clear_counts),
    .pulse_valid       (pulse_valid),
    .pulse_phase       (pulse_phase),
    .glitch_count      (glitch_count),
    .pile_up_count     (pile_up_count)
  );

  // Per-cycle stimulus (inputs held during cycle k), model expectations and observations.
  bit            st_pin[MAXN], st_lsf[MAXN], st_clr[MAXN];
  int            st_mw[MAXN], st_dt[MAXN];
  bit            st_pin_rst;
  int            n_cyc;
  bit            ex_valid[MAXN], ex_phase[MAXN];
  int            ex_gc[MAXN], ex_pc[MAXN];
  logic          ob_valid[MAXN], ob_phase[MAXN];
  logic [CW-1:0] ob_gc[MAXN], ob_pc[MAXN];

  task automatic init_stim(input int n, input int mw, input int dt);
    n_cyc = n;
    st_pin_rst = 1'b0;
    for (int k = 0; k < MAXN; k++) begin
      st_pin[k] = 1'b0; st_lsf[k] = 1'b0; st_clr[k] = 1'b0;
      st_mw[k] = mw; st_dt[k] = dt;
    end
  endtask

  task automatic pin_high(input int from, input int len);
    for (int k = from; k < from + len; k++) st_pin[k] = 1'b1;
  endtask

  // Works on whole high-runs of the synchronised line: each rise is either
  // swallowed by an earlier pulse's dead/hold window, or qualifies/glitches.
  task automatic run_model();
    bit s[MAXN];
    int ginc[MAXN], pinc[MAXN];
    int free_at, h, wm, a, c, j, gc, pc;
    for (int k = 0; k < n_cyc; k++) begin
      j = k - SYNC;
      s[k] = (j < -1) ? 1'b1 : ((j == -1) ? st_pin_rst : st_pin[j]);
      ginc[k] = 0; pinc[k] = 0; ex_valid[k] = 1'b0; ex_phase[k] = 1'b0;
    end
    free_at = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (s[k] && (k > 0) && !s[k-1]) begin
        if (k < free_at) begin
          pinc[k]++;
        end else begin
          h = 0;
          while ((k + h < n_cyc) && s[k+h]) h++;
          wm = (st_mw[k] == 0) ? 1 : st_mw[k];
          if (h >= wm) begin
            a = k + wm - 1;
            if (a + 1 < n_cyc) begin
              ex_valid[a+1] = 1'b1;
              ex_phase[a+1] = st_lsf[k];
            end
            c = a + 1 + st_dt[a];
            if (c >= n_cyc) free_at = n_cyc;
            else if (!s[c]) free_at = c + 1;
            else begin
              j = c + 1;
              while ((j < n_cyc) && s[j]) j++;
              free_at = j + 1;
            end
          end else if (k + h < n_cyc) begin
            ginc[k+h]++;
            free_at = k + h + 1;
          end else begin
            free_at = n_cyc;
          end
        end
      end
    end
    gc = 0; pc = 0;
    for (int k = 0; k < n_cyc; k++) begin
      ex_gc[k] = gc; ex_pc[k] = pc;
      if (st_clr[k]) begin
        gc = 0; pc = 0;
      end else begin
        gc = (gc + ginc[k] > CMAX) ? CMAX : gc + ginc[k];
`ifdef PMT_PILEUP_CNT_EN
        pc = (pc + pinc[k] > CMAX) ? CMAX : pc + pinc[k];
`endif
      end
    end
  endtask

  task automatic apply();
    reset_n = 1'b0; pmt_in = st_pin_rst; clear_counts = 1'b0;
    light_source_flag = 1'b0; min_width = '0; dead_time = '0;
    repeat (3) @(negedge clock_50_mhz);
    reset_n = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clock_50_mhz);
      ob_valid[k] = pulse_valid; ob_phase[k] = pulse_phase;
      ob_gc[k] = glitch_count;   ob_pc[k] = pile_up_count;
      pmt_in = st_pin[k]; light_source_flag = st_lsf[k];
      min_width = MW_W'(st_mw[k]); dead_time = DT_W'(st_dt[k]); clear_counts = st_clr[k];
    end
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int k = 0; k < n_cyc; k++) if (ob_valid[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_valid(input int from);
    for (int k = from; k < n_cyc; k++) if (ob_valid[k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; pmt_in = 1'b0; clear_counts = 1'b0;
    repeat (2) @(negedge clock_50_mhz);
    vectors++;
    if ({pulse_valid, pulse_phase} !== 2'b00) begin
      miscompares++; $display("FAIL reset_strobe: got %b%b want 00", pulse_valid, pulse_phase);
    end
    vectors++;
    if (glitch_count !== '0) begin
      miscompares++; $display("FAIL reset_glitch: got %0d want 0", glitch_count);
    end
    vectors++;
    if (pile_up_count !== '0) begin
      miscompares++; $display("FAIL reset_pileup: got %0d want 0", pile_up_count);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clock_50_mhz);
    vectors++;
    if (pulse_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: got %b want 0", pulse_valid);
    end
  endtask

  task automatic test_accept();
    init_stim(40, 3, 10);
    pin_high(5, 5);
    for (int k = 0; k < 40; k++) st_lsf[k] = 1'b1;
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || (ex_valid[k] && ob_phase[k] !== ex_phase[k]) ||
          ob_gc[k] !== CW'(ex_gc[k]) || ob_pc[k] !== CW'(ex_pc[k])) begin
        miscompares++;
        $display("FAIL accept cyc %0d: got v%b p%b g%0d u%0d want v%b p%b g%0d u%0d", k,
                 ob_valid[k], ob_phase[k], ob_gc[k], ob_pc[k], ex_valid[k], ex_phase[k], ex_gc[k], ex_pc[k]);
      end
    end
    vectors++;
    if (first_valid(0) != 5 + SYNC + 3 || count_valid() != 1) begin
      miscompares++; $display("FAIL accept_latency: got cyc %0d n %0d want cyc %0d n 1",
                              first_valid(0), count_valid(), 5 + SYNC + 3);
    end
    vectors++;
    if (ob_phase[5+SYNC+3] !== 1'b1 || ob_gc[39] !== '0 || ob_pc[39] !== '0) begin
      miscompares++; $display("FAIL accept_tags: got p%b g%0d u%0d want p1 g0 u0",
                              ob_phase[5+SYNC+3], ob_gc[39], ob_pc[39]);
    end
  endtask

  task automatic test_glitch();
    init_stim(6 * 270 + 10, 4, 5);
    for (int i = 0; i < 270; i++) pin_high(6 * i + 2, 2);
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_gc[k] !== CW'(ex_gc[k]) || ob_pc[k] !== CW'(ex_pc[k])) begin
        miscompares++;
        $display("FAIL glitch cyc %0d: got v%b g%0d u%0d want v%b g%0d u%0d", k,
                 ob_valid[k], ob_gc[k], ob_pc[k], ex_valid[k], ex_gc[k], ex_pc[k]);
      end
    end
    vectors++;
    if (ob_gc[2+SYNC+3] !== CW'(1)) begin
      miscompares++; $display("FAIL glitch_first: got %0d want 1", ob_gc[2+SYNC+3]);
    end
    vectors++;
    if (ob_gc[n_cyc-1] !== CW'(CMAX) || count_valid() != 0) begin
      miscompares++; $display("FAIL glitch_saturate: got %0d n %0d want %0d n 0",
                              ob_gc[n_cyc-1], count_valid(), CMAX);
    end
  endtask

  task automatic test_pileup();
    int exp_pc;
`ifdef PMT_PILEUP_CNT_EN
    exp_pc = 3;
`else
    exp_pc = 0;
`endif
    init_stim(80, 1, 20);
    for (int i = 0; i < 4; i++) pin_high(4 + 6 * i, 2);
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_gc[k] !== CW'(ex_gc[k]) || ob_pc[k] !== CW'(ex_pc[k])) begin
        miscompares++;
        $display("FAIL pileup cyc %0d: got v%b g%0d u%0d want v%b g%0d u%0d", k,
                 ob_valid[k], ob_gc[k], ob_pc[k], ex_valid[k], ex_gc[k], ex_pc[k]);
      end
    end
    vectors++;
    if (count_valid() != 1 || ob_pc[79] !== CW'(exp_pc)) begin
      miscompares++; $display("FAIL pileup_total: got n %0d u%0d want n 1 u%0d",
                              count_valid(), ob_pc[79], exp_pc);
    end
  endtask

  task automatic test_hold();
    init_stim(90, 1, 2);
    pin_high(3, 50);
    pin_high(63, 3);
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_gc[k] !== CW'(ex_gc[k]) || ob_pc[k] !== CW'(ex_pc[k])) begin
        miscompares++;
        $display("FAIL hold cyc %0d: got v%b g%0d u%0d want v%b g%0d u%0d", k,
                 ob_valid[k], ob_gc[k], ob_pc[k], ex_valid[k], ex_gc[k], ex_pc[k]);
      end
    end
    vectors++;
    if (count_valid() != 2 || first_valid(0) != 3 + SYNC + 1 || first_valid(10) != 63 + SYNC + 1) begin
      miscompares++; $display("FAIL hold_pulses: got n %0d at %0d,%0d want n 2 at %0d,%0d",
                              count_valid(), first_valid(0), first_valid(10), 3 + SYNC + 1, 63 + SYNC + 1);
    end
  endtask

  task automatic test_phase();
    init_stim(70, 6, 3);
    pin_high(4, 12);
    pin_high(40, 12);
    for (int k = 0; k < 70; k++) st_lsf[k] = (k <= 4 + SYNC) || (k > 40 + SYNC);
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || (ex_valid[k] && ob_phase[k] !== ex_phase[k])) begin
        miscompares++;
        $display("FAIL phase cyc %0d: got v%b p%b want v%b p%b", k,
                 ob_valid[k], ob_phase[k], ex_valid[k], ex_phase[k]);
      end
    end
    vectors++;
    if (ob_valid[4+SYNC+6] !== 1'b1 || ob_phase[4+SYNC+6] !== 1'b1 ||
        ob_valid[40+SYNC+6] !== 1'b1 || ob_phase[40+SYNC+6] !== 1'b0) begin
      miscompares++; $display("FAIL phase_latch: got v%b p%b v%b p%b want v1 p1 v1 p0",
                              ob_valid[4+SYNC+6], ob_phase[4+SYNC+6], ob_valid[40+SYNC+6], ob_phase[40+SYNC+6]);
    end
  endtask

  task automatic test_reset_clear();
    init_stim(40, 1, 0);
    st_pin_rst = 1'b1;
    pin_high(0, 10);
    pin_high(20, 4);
    run_model(); apply();
    vectors++;
    if (count_valid() != 1 || first_valid(0) != 20 + SYNC + 1) begin
      miscompares++; $display("FAIL high_at_release: got n %0d at %0d want n 1 at %0d",
                              count_valid(), first_valid(0), 20 + SYNC + 1);
    end

    init_stim(40, 4, 2);
    pin_high(5, 2);
    pin_high(20, 2);
    st_clr[5+SYNC+2] = 1'b1;
    run_model(); apply();
    for (int k = 0; k < n_cyc; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_gc[k] !== CW'(ex_gc[k])) begin
        miscompares++;
        $display("FAIL clear cyc %0d: got v%b g%0d want v%b g%0d", k, ob_valid[k], ob_gc[k], ex_valid[k], ex_gc[k]);
      end
    end
    vectors++;
    if (ob_gc[5+SYNC+3] !== '0 || ob_gc[39] !== CW'(1)) begin
      miscompares++; $display("FAIL clear_wins: got %0d then %0d want 0 then 1", ob_gc[5+SYNC+3], ob_gc[39]);
    end

    reset_n = 1'b0; pmt_in = 1'b0; min_width = MW_W'(6); dead_time = DT_W'(4); clear_counts = 1'b0;
    repeat (2) @(negedge clock_50_mhz);
    reset_n = 1'b1;
    repeat (3) @(negedge clock_50_mhz);
    pmt_in = 1'b1;
    repeat (SYNC + 2) @(negedge clock_50_mhz);
    reset_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_50_mhz);
      if (i == 8) reset_n = 1'b1;
      if (i == 20) pmt_in = 1'b0;
      vectors++;
      if (pulse_valid !== 1'b0 || glitch_count !== '0 || pile_up_count !== '0) begin
        miscompares++; $display("FAIL mid_qualify_reset step %0d: got v%b g%0d u%0d want v0 g0 u0",
                                i, pulse_valid, glitch_count, pile_up_count);
      end
    end
  endtask

  task automatic test_random(input int n);
    int k, len;
    init_stim(n, 1, 0);
    st_pin_rst = 1'($urandom_range(0, 1));
    k = 0;
    while (k < n) begin
      len = $urandom_range(1, 12); k += len;
      len = $urandom_range(1, 10);
      if (k < n) pin_high(k, (k + len > n) ? n - k : len);
      k += len;
    end
    for (int i = 0; i < n; i++) begin
      if (i % 50 == 0) begin
        st_mw[i] = $urandom_range(0, 5); st_dt[i] = $urandom_range(0, 12);
      end else begin
        st_mw[i] = st_mw[i-1]; st_dt[i] = st_dt[i-1];
      end
      st_lsf[i] = 1'($urandom_range(0, 1));
      st_clr[i] = ($urandom_range(0, 199) == 0);
    end
    run_model(); apply();
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (ob_valid[i] !== ex_valid[i] || (ex_valid[i] && ob_phase[i] !== ex_phase[i]) ||
          ob_gc[i] !== CW'(ex_gc[i]) || ob_pc[i] !== CW'(ex_pc[i])) begin
        miscompares++;
        $display("FAIL random cyc %0d: got v%b p%b g%0d u%0d want v%b p%b g%0d u%0d", i,
                 ob_valid[i], ob_phase[i], ob_gc[i], ob_pc[i], ex_valid[i], ex_phase[i], ex_gc[i], ex_pc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_pileup();
    test_hold();
    test_phase();
    test_reset_clear();
    for (int r = 0; r < 3; r++) test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
